// File: rtl/mw_pipe_stage.sv
// ---------------------------------------------------------------------------
// mw_pipe_stage
//   MEM->WB pipeline stage register with a valid/ready handshake on both
//   sides. The stage holds up to two entries: a head ("main") that drives
//   out_*, and an optional skid entry. The skid entry lets in_ready be a
//   plain flop, so there is no combinational path from out_ready.
//   out_wreg/out_m2reg are masked with out_valid so that the register file is
//   never written on a bubble.
//
// Parameters
//   DATA_W : width of ALU result and memory read data
//   RD_W   : width of destination register index
//   SKID   : 1 = two entries, in_ready registered
//            0 = single entry, in_ready combinational from out_ready
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   flush                 : drop every held and incoming entry
//   in_valid / in_ready   : upstream handshake
//   in_wreg, in_m2reg,
//   in_rd, in_r, in_data  : upstream payload
//   out_valid / out_ready : downstream handshake (head entry)
//   out_wreg, out_m2reg   : head controls, gated by out_valid
//   out_rd, out_r,
//   out_data              : head payload (holds last value while invalid)
//   occupancy             : number of held entries, 0..2
// ---------------------------------------------------------------------------
module mw_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int SKID   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wreg,
  input  logic              in_m2reg,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wreg,
  output logic              out_m2reg,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Payload layout: {wreg, m2reg, rd, r, data}
  localparam int PW = 2 + RD_W + 2 * DATA_W;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_reg, main_next;
  logic [PW-1:0] skid_reg, skid_next;
  logic          main_valid_reg, main_valid_next;
  logic          skid_valid_reg, skid_valid_next;
  // SKID=1: registered "not full". SKID=0: "out of reset" qualifier.
  logic          ready_reg, ready_next;
  logic          accept;
  logic          rel;

  assign in_payload = {in_wreg, in_m2reg, in_rd, in_r, in_data};
  assign accept     = in_valid & in_ready;
  assign rel        = main_valid_reg & out_ready;

  always_comb begin
    main_next       = main_reg;
    skid_next       = skid_reg;
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    if (skid_valid_reg) begin
      // FULL: in_ready is low, so only a release can happen; skid moves up.
      if (rel) begin
        main_next       = skid_reg;
        skid_valid_next = 1'b0;
      end
    end else if (main_valid_reg) begin
      // ONE. With SKID=0 an accept here implies a release, so the skid
      // branch is never taken in that build.
      if (accept && rel) begin
        main_next = in_payload;
      end else if (accept) begin
        skid_next       = in_payload;
        skid_valid_next = 1'b1;
      end else if (rel) begin
        main_valid_next = 1'b0;
      end
    end else if (accept) begin
      main_next       = in_payload;
      main_valid_next = 1'b1;
    end
    ready_next = (SKID != 0) ? ~skid_valid_next : 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      main_reg       <= '0;
      skid_reg       <= '0;
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b0;
    end else if (flush) begin
      // Payload is kept; only the valids are dropped. The stage is empty
      // afterwards, so it is ready on the next cycle.
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      ready_reg      <= 1'b1;
    end else begin
      main_reg       <= main_next;
      skid_reg       <= skid_next;
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      ready_reg      <= ready_next;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = ready_reg;
    end else begin : g_noskid
      assign in_ready = ready_reg & (~main_valid_reg | out_ready);
    end
  endgenerate

  assign out_valid = main_valid_reg;
  assign out_wreg  = main_reg[PW-1] & main_valid_reg;
  assign out_m2reg = main_reg[PW-2] & main_valid_reg;
  assign out_rd    = main_reg[2*DATA_W +: RD_W];
  assign out_r     = main_reg[DATA_W +: DATA_W];
  assign out_data  = main_reg[0 +: DATA_W];
  assign occupancy = {1'b0, main_valid_reg} + {1'b0, skid_valid_reg};

endmodule

// File: tb/tb_mw_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_mw_pipe_stage
//   Two instances share clock and reset: index 0 is built with SKID=1 and
//   index 1 with SKID=0. A FIFO model with a capacity of two entries predicts
//   every output on every cycle. Directed sequences with literal
//   expectations pin the model itself.
// ---------------------------------------------------------------------------
module tb_mw_pipe_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  typedef struct packed {
    logic          wreg;
    logic          m2reg;
    logic [RW-1:0] rd;
    logic [DW-1:0] r;
    logic [DW-1:0] data;
  } ent_t;

  logic clock = 1'b0;
  logic reset;
  logic [1:0]          flush, in_valid, in_ready, in_wreg, in_m2reg;
  logic [1:0]          out_valid, out_ready, out_wreg, out_m2reg;
  logic [1:0][RW-1:0]  in_rd, out_rd;
  logic [1:0][DW-1:0]  in_r, in_data, out_r, out_data;
  logic [1:0][1:0]     occupancy;

  always #5 clock = ~clock;

  mw_pipe_stage #(.DATA_W(DW), .RD_W(RW), .SKID(1)) u_skid (
    .clock(clock), .reset(reset), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_wreg(in_wreg[0]), .in_m2reg(in_m2reg[0]), .in_rd(in_rd[0]),
    .in_r(in_r[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_wreg(out_wreg[0]), .out_m2reg(out_m2reg[0]), .out_rd(out_rd[0]),
    .out_r(out_r[0]), .out_data(out_data[0]), .occupancy(occupancy[0])
  );

  mw_pipe_stage #(.DATA_W(DW), .RD_W(RW), .SKID(0)) u_noskid (
    .clock(clock), .reset(reset), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_wreg(in_wreg[1]), .in_m2reg(in_m2reg[1]), .in_rd(in_rd[1]),
    .in_r(in_r[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_wreg(out_wreg[1]), .out_m2reg(out_m2reg[1]), .out_rd(out_rd[1]),
    .out_r(out_r[1]), .out_data(out_data[1]), .occupancy(occupancy[1])
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int inst,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  ent_t mq [2][2];
  int   mcnt [2];
  ent_t mlast [2];
  bit   started [2];
  bit   live = 1'b0;

  function automatic bit exp_ready(input int i);
    if (!started[i]) return 1'b0;
    if (i == 0) return mcnt[i] != 2;
    return (mcnt[i] == 0) || (out_ready[i] == 1'b1);
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      bit   acc;
      bit   rls;
      ent_t e;
      acc = (in_valid[i] == 1'b1) && exp_ready(i);
      rls = (mcnt[i] > 0) && (out_ready[i] == 1'b1);
      e.wreg  = in_wreg[i];
      e.m2reg = in_m2reg[i];
      e.rd    = in_rd[i];
      e.r     = in_r[i];
      e.data  = in_data[i];
      if (reset) begin
        mcnt[i]    = 0;
        mlast[i]   = '0;
        started[i] = 1'b0;
      end else begin
        if (rls) begin
          mq[i][0] = mq[i][1];
          mcnt[i]  = mcnt[i] - 1;
        end
        if (acc && mcnt[i] < 2) begin
          mq[i][mcnt[i]] = e;
          mcnt[i] = mcnt[i] + 1;
        end
        if (flush[i]) mcnt[i] = 0;
        if (mcnt[i] > 0) mlast[i] = mq[i][0];
        started[i] = 1'b1;
      end
    end
    live = 1'b1;
  end

  always @(negedge clock) begin
    if (live) begin
      for (int i = 0; i < 2; i++) begin
        bit v;
        v = mcnt[i] > 0;
        chk("m_out_valid", i, out_valid[i], v);
        chk("m_occupancy", i, occupancy[i], mcnt[i]);
        chk("m_in_ready",  i, in_ready[i], exp_ready(i));
        chk("m_out_wreg",  i, out_wreg[i], v & mlast[i].wreg);
        chk("m_out_m2reg", i, out_m2reg[i], v & mlast[i].m2reg);
        chk("m_out_rd",    i, out_rd[i], mlast[i].rd);
        chk("m_out_r",     i, out_r[i], mlast[i].r);
        chk("m_out_data",  i, out_data[i], mlast[i].data);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int i, input bit v, input bit w, input bit m,
                       input int rd, input int r);
    in_valid[i] = v;
    in_wreg[i]  = w;
    in_m2reg[i] = m;
    in_rd[i]    = RW'(rd);
    in_r[i]     = DW'(r);
    in_data[i]  = DW'(r) ^ 32'hA5A5_0000;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = '0;
    out_ready = '0;
    drive(0, 1, 1, 1, 1, 'h11);
    drive(1, 1, 1, 1, 1, 'h11);

    // Reset held two cycles with in_valid high
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      chk("t1_out_valid", i, out_valid[i], 0);
      chk("t1_occupancy", i, occupancy[i], 0);
      chk("t1_out_r",     i, out_r[i], 0);
      chk("t1_in_ready",  i, in_ready[i], 0);
    end
    reset    = 1'b0;
    in_valid = '0;
    step();
    for (int i = 0; i < 2; i++) chk("t1_ready_after", i, in_ready[i], 1);

    // Streaming, one entry per cycle
    out_ready = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      drive(0, 1, k[0], k[1], k, 'h100 + k);
      drive(1, 1, k[0], k[1], k, 'h100 + k);
      step();
      for (int i = 0; i < 2; i++) begin
        chk("t2_valid", i, out_valid[i], 1);
        chk("t2_rd",    i, out_rd[i], k);
        chk("t2_r",     i, out_r[i], 'h100 + k);
      end
    end
    in_valid = '0;
    step();
    for (int i = 0; i < 2; i++) chk("t2_drain", i, out_valid[i], 0);

    // Backpressure fills the skid entry
    out_ready[0] = 1'b0;
    drive(0, 1, 1, 0, 3, 'h300);
    step();
    drive(0, 1, 1, 0, 4, 'h400);
    step();
    in_valid[0] = 1'b0;
    chk("t3_occupancy", 0, occupancy[0], 2);
    chk("t3_in_ready",  0, in_ready[0], 0);
    chk("t3_out_rd",    0, out_rd[0], 3);
    out_ready[0] = 1'b1;
    step();
    chk("t3_second_rd", 0, out_rd[0], 4);
    chk("t3_ready_back", 0, in_ready[0], 1);
    chk("t3_occ_one",   0, occupancy[0], 1);
    step();
    chk("t3_empty", 0, out_valid[0], 0);

    // Flush while full with an incoming entry
    out_ready[0] = 1'b0;
    drive(0, 1, 1, 1, 5, 'h500);
    step();
    drive(0, 1, 1, 1, 6, 'h600);
    step();
    drive(0, 1, 1, 1, 9, 'h900);
    flush[0] = 1'b1;
    step();
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    chk("t4_valid",     0, out_valid[0], 0);
    chk("t4_wreg",      0, out_wreg[0], 0);
    chk("t4_occupancy", 0, occupancy[0], 0);
    out_ready[0] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("t4_no_rd9", 0, out_valid[0], 0);
    end
    // Flush on the same edge as an accept drops the accepted entry
    out_ready[0] = 1'b0;
    drive(0, 1, 0, 0, 10, 'hA00);
    step();
    drive(0, 1, 0, 0, 11, 'hB00);
    flush[0] = 1'b1;
    step();
    flush[0]    = 1'b0;
    in_valid[0] = 1'b0;
    chk("t4b_occupancy", 0, occupancy[0], 0);

    // Bubble masking
    drive(0, 1, 1, 1, 7, 'h700);
    step();
    in_valid[0] = 1'b0;
    chk("t5_wreg_live",  0, out_wreg[0], 1);
    chk("t5_m2reg_live", 0, out_m2reg[0], 1);
    out_ready[0] = 1'b1;
    step();
    chk("t5_valid", 0, out_valid[0], 0);
    chk("t5_wreg",  0, out_wreg[0], 0);
    chk("t5_m2reg", 0, out_m2reg[0], 0);
    chk("t5_rd",    0, out_rd[0], 7);

    // Combinational in_ready of the SKID=0 build
    out_ready[1] = 1'b0;
    drive(1, 1, 1, 0, 11, 'hB00);
    step();
    drive(1, 1, 1, 0, 12, 'hC00);
    chk("t6_valid",     1, out_valid[1], 1);
    chk("t6_ready_low", 1, in_ready[1], 0);
    out_ready[1] = 1'b1;
    #1;
    chk("t6_ready_high", 1, in_ready[1], 1);
    step();
    chk("t6_occupancy", 1, occupancy[1], 1);
    chk("t6_rd",        1, out_rd[1], 12);
    in_valid[1] = 1'b0;
    step();
    chk("t6_empty", 1, out_valid[1], 0);

    // Reset in the middle of traffic
    out_ready[0] = 1'b0;
    drive(0, 1, 1, 0, 13, 'hD00);
    step();
    drive(0, 1, 1, 0, 14, 'hE00);
    step();
    in_valid[0] = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t7_occupancy", 0, occupancy[0], 0);
    chk("t7_out_r",     0, out_r[0], 0);
    chk("t7_in_ready",  0, in_ready[0], 0);
    step();
    chk("t7_ready_after", 0, in_ready[0], 1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
